// File: rtl/semafor_pkg.sv
// rtl/semafor_pkg.sv - shared phase codes, state enum and output decode for the intersection sequencer
//
// Purpose : constants and types shared by secventiator_faze and its timer.
// Ports   : none (package).
// Config  : SECV_NOAPTE_EN only affects users of NOAPTE; the enum always carries it.
package semafor_pkg;

    localparam logic [1:0] COD_ROSU       = 2'b00;
    localparam logic [1:0] COD_GALBEN     = 2'b01;
    localparam logic [1:0] COD_VERDE      = 2'b10;
    localparam logic [1:0] COD_ROSU_TOTAL = 2'b11;

    typedef enum logic [2:0] {
        RT_A     = 3'd0,
        VERDE_V  = 3'd1,
        GALBEN_V = 3'd2,
        RT_B     = 3'd3,
        VERDE_O  = 3'd4,
        GALBEN_O = 3'd5,
        NOAPTE   = 3'd6
    } faza_t;

    typedef struct packed {
        logic [1:0] w_v;
        logic       tr_v;
        logic [1:0] w_o;
        logic       tr_o;
    } iesiri_t;

    // Output pattern seen by both light controllers for a given phase.
    function automatic iesiri_t decod_faza(faza_t f);
        iesiri_t r;
        case (f)
            VERDE_V:  r = '{COD_VERDE,      1'b0, COD_ROSU,       1'b0};
            GALBEN_V: r = '{COD_GALBEN,     1'b1, COD_ROSU,       1'b0};
            VERDE_O:  r = '{COD_ROSU,       1'b0, COD_VERDE,      1'b0};
            GALBEN_O: r = '{COD_ROSU,       1'b0, COD_GALBEN,     1'b1};
            NOAPTE:   r = '{COD_GALBEN,     1'b1, COD_GALBEN,     1'b1};
            default:  r = '{COD_ROSU_TOTAL, 1'b0, COD_ROSU_TOTAL, 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secventiator_faze_temporizator.sv
// rtl/secventiator_faze_temporizator.sv - phase tick counter with clear and terminal match
//
// Purpose : counts prescaler ticks inside one phase and flags the tick that ends it.
// Ports   : clk_i, rst_n_i (sync, active-low)
//           clr_i   - force counter to 0 on next edge (wins over en_i)
//           en_i    - counted tick this cycle
//           term_i  - terminal value (phase duration - 1)
//           cnt_o   - current count
//           exp_o   - 1 when this cycle's counted tick is the last of the phase
module temporizator_faza #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             exp_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign exp_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/secventiator_faze.sv
// rtl/secventiator_faze.sv - two-road intersection phase sequencer
//
// Purpose : timed cycle RT_A -> VERDE_V -> GALBEN_V -> RT_B -> VERDE_O -> GALBEN_O,
//           with early end of V green on a latched O-side request.
// Ports   : clk_i, rst_n_i (sync, active-low), enable_i, tick_i, cerere_o_i, noapte_i
//           w_v_o[1:0], tranzit_v_o, w_o_o[1:0], tranzit_o_o, enable_o (all registered)
// Config  : SECV_NOAPTE_EN adds the night state (both roads flashing yellow);
//           without it noapte_i is ignored.
module secventiator_faze
    import semafor_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int T_VERDE_V    = 20,
    parameter int T_MIN_V      = 8,
    parameter int T_VERDE_O    = 15,
    parameter int T_GALBEN     = 3,
    parameter int T_ROSU_TOTAL = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic       cerere_o_i,
    input  logic       noapte_i,
    output logic [1:0] w_v_o,
    output logic       tranzit_v_o,
    output logic [1:0] w_o_o,
    output logic       tranzit_o_o,
    output logic       enable_o
);

    localparam logic [CNT_W-1:0] TERM_VERDE_V = CNT_W'(T_VERDE_V - 1);
    localparam logic [CNT_W-1:0] TERM_VERDE_O = CNT_W'(T_VERDE_O - 1);
    localparam logic [CNT_W-1:0] TERM_GALBEN  = CNT_W'(T_GALBEN - 1);
    localparam logic [CNT_W-1:0] TERM_ROSU    = CNT_W'(T_ROSU_TOTAL - 1);
    localparam logic [CNT_W-1:0] PRAG_MIN_V   = CNT_W'(T_MIN_V - 1);

    faza_t            state_q, state_d;
    logic             cerere_q, cerere_d;
    iesiri_t          iesiri_q, iesiri_d;
    logic             enable_q;

    logic             cnt_en;
    logic             cnt_clr;
    logic             expirat;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt;

    assign cnt_en = enable_i && tick_i;

    temporizator_faza #(.CNT_W(CNT_W)) u_temporizator (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (term),
        .cnt_o   (cnt),
        .exp_o   (expirat)
    );

`ifndef SECV_NOAPTE_EN
    logic unused_noapte;
    assign unused_noapte = noapte_i;
`endif

    always_comb begin
        state_d  = state_q;
        cerere_d = cerere_q;
        term     = TERM_ROSU;

        case (state_q)
            VERDE_V:  term = TERM_VERDE_V;
            GALBEN_V: term = TERM_GALBEN;
            VERDE_O:  term = TERM_VERDE_O;
            GALBEN_O: term = TERM_GALBEN;
            default:  term = TERM_ROSU;
        endcase

        case (state_q)
            RT_A: begin
                if (expirat) state_d = VERDE_V;
`ifdef SECV_NOAPTE_EN
                if (cnt_en && noapte_i) state_d = NOAPTE;
`endif
            end
            // Natural expiry and early cut both land in GALBEN_V, so a
            // coinciding request cannot cause a double step.
            VERDE_V: begin
                if (expirat || (cnt_en && (cerere_q || cerere_o_i) && cnt >= PRAG_MIN_V))
                    state_d = GALBEN_V;
            end
            GALBEN_V: if (expirat) state_d = RT_B;
            RT_B: begin
                if (expirat) state_d = VERDE_O;
`ifdef SECV_NOAPTE_EN
                if (cnt_en && noapte_i) state_d = NOAPTE;
`endif
            end
            VERDE_O:  if (expirat) state_d = GALBEN_O;
            GALBEN_O: if (expirat) state_d = RT_A;
`ifdef SECV_NOAPTE_EN
            NOAPTE:   if (cnt_en && !noapte_i) state_d = RT_A;
`endif
            default:  state_d = RT_A;
        endcase

        // Requests are remembered even while frozen; serving O clears them.
        if (cerere_o_i && (state_q == RT_A || state_q == VERDE_V ||
                           state_q == GALBEN_V || state_q == RT_B))
            cerere_d = 1'b1;
        if (state_d == VERDE_O && state_q != VERDE_O)
            cerere_d = 1'b0;

        // Counter restarts on every phase change and stays at 0 in NOAPTE.
        cnt_clr  = (state_d != state_q) || (state_q == NOAPTE);
        iesiri_d = decod_faza(state_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= RT_A;
            cerere_q <= 1'b0;
            iesiri_q <= decod_faza(RT_A);
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cerere_q <= cerere_d;
            iesiri_q <= iesiri_d;
            enable_q <= enable_i;
        end
    end

    assign w_v_o       = iesiri_q.w_v;
    assign tranzit_v_o = iesiri_q.tr_v;
    assign w_o_o       = iesiri_q.w_o;
    assign tranzit_o_o = iesiri_q.tr_o;
    assign enable_o    = enable_q;

endmodule

// File: tb/tb_secventiator_faze.sv
// tb/tb_secventiator_faze.sv - scoreboard bench for secventiator_faze
module tb_secventiator_faze;

    logic       clk = 1'b0;
    logic       rst_n, en, tick, cer, noap;
    logic [1:0] w_v, w_o;
    logic       tr_v, tr_o, en_o;

    always #5 clk = ~clk;

    secventiator_faze dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (en),
        .tick_i      (tick),
        .cerere_o_i  (cer),
        .noapte_i    (noap),
        .w_v_o       (w_v),
        .tranzit_v_o (tr_v),
        .w_o_o       (w_o),
        .tranzit_o_o (tr_o),
        .enable_o    (en_o)
    );

    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase index 0..5 (6 = night), ticks elapsed in phase, pending request.
    int m_ph  = 0;
    int m_el  = 0;
    bit m_req = 0;
    int cer_ph = -1;
    int cer_el = -1;

    function automatic int dur(int ph);
        case (ph)
            0: return 2;
            1: return 20;
            2: return 3;
            3: return 2;
            4: return 15;
            5: return 3;
            default: return 0;
        endcase
    endfunction

    // {w_v, tr_v, w_o, tr_o} as listed in the phase table.
    function automatic logic [5:0] look(int ph);
        case (ph)
            1: return 6'b10_0_00_0;
            2: return 6'b01_1_00_0;
            4: return 6'b00_0_10_0;
            5: return 6'b00_0_01_1;
            6: return 6'b01_1_01_1;
            default: return 6'b11_0_11_0;
        endcase
    endfunction

    task automatic step(bit r, bit e, bit t, bit c, bit n);
        int nxt;
        rst_n = r; en = e; tick = t; cer = c; noap = n;
        if (!r) begin
            m_ph = 0; m_el = 0; m_req = 0;
        end else begin
            if (c && m_ph <= 3) m_req = 1;
            if (e && t) begin
                nxt = m_ph;
                m_el++;
                if (m_ph < 6 && m_el == dur(m_ph)) nxt = (m_ph + 1) % 6;
                if (m_ph == 1 && m_req && m_el >= 8) nxt = 2;
`ifdef SECV_NOAPTE_EN
                if ((m_ph == 0 || m_ph == 3) && n) nxt = 6;
                if (m_ph == 6) begin
                    nxt  = n ? 6 : 0;
                    m_el = 0;
                end
`endif
                if (nxt != m_ph) begin
                    m_el = 0;
                    if (nxt == 4) m_req = 0;
                    m_ph = nxt;
                end
            end
        end
        exp_q.push_back({look(m_ph), r & e});
        @(posedge clk);
        #1;
    endtask

    task automatic tick_step(int per, bit e, bit n);
        bit t;
        bit c;
        t = (cyc % per) == (per - 1);
        cyc++;
        c = (m_ph == cer_ph) && (m_el == cer_el);
        step(1'b1, e, t, c, n);
    endtask

    task automatic run(int n, int per, bit e);
        for (int i = 0; i < n; i++) tick_step(per, e, 1'b0);
    endtask

    task automatic run_until(int ph, int el, int per);
        int k;
        k = 0;
        while (!(m_ph == ph && m_el == el) && k < 2000) begin
            tick_step(per, 1'b1, 1'b0);
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_bad++;
            $display("FAIL reach_phase: model stuck at phase %0d elapsed %0d, required phase %0d elapsed %0d",
                     m_ph, m_el, ph, el);
        end
    endtask

    initial begin : monitor
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({w_v, tr_v, w_o, tr_o, en_o} !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got w_v=%b tr_v=%b w_o=%b tr_o=%b en_o=%b, expected %b",
                             $time, w_v, tr_v, w_o, tr_o, en_o, e);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; en = 1'b0; tick = 1'b0; cer = 1'b0; noap = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Full undisturbed cycle, tick every 4 clocks.
        run(190, 4, 1'b1);

        // Early request at V green tick 3.
        run_until(1, 3, 4);
        cer_ph = 1; cer_el = 3;
        run_until(2, 0, 4);
        cer_ph = -1; cer_el = -1;
        run(40, 4, 1'b1);

        // Late request at V green tick 12, then check latch clears after O green.
        run_until(1, 12, 4);
        cer_ph = 1; cer_el = 12;
        run_until(4, 0, 4);
        cer_ph = -1; cer_el = -1;
        run(200, 4, 1'b1);

        // Freeze mid O green with ticks running.
        run_until(4, 5, 4);
        run(50, 4, 1'b0);
        run(100, 4, 1'b1);

        // Reset pulse during V yellow.
        run_until(2, 1, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(80, 4, 1'b1);

        // Night request during RT_B, then released.
        run_until(3, 0, 4);
        for (int i = 0; i < 12; i++) tick_step(2, 1'b1, 1'b1);
        run(40, 4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
